// File: rtl/lsu_byte_seq.sv
// Byte-serial load/store initiator: splits one RV32I load/store into
// single-byte memory transactions, little-endian, lowest address first.
//
// state | meaning
// IDLE  | ready for a request; latches it on req_valid
// XFER  | one byte transaction per cycle, idx = current byte
// RESP  | one-cycle response pulse, then back to IDLE
module lsu_byte_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t      state, state_nxt;
    logic        we_q;
    logic        err_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] data_buf;
    logic [1:0]  idx;
    logic [1:0]  last_idx;
    logic        illegal;
    logic        accept;
    logic [31:0] ext_data;

    assign illegal = (req_funct3[1:0] == 2'b11)
                   || (!req_we && (req_funct3 == 3'b110))
                   || (req_we && req_funct3[2]);

    assign accept = (state == IDLE) && req_valid;

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    always_comb begin
        case (funct3_q)
            3'b000:  ext_data = {{24{data_buf[7]}}, data_buf[7:0]};
            3'b001:  ext_data = {{16{data_buf[15]}}, data_buf[15:0]};
            3'b100:  ext_data = {24'b0, data_buf[7:0]};
            3'b101:  ext_data = {16'b0, data_buf[15:0]};
            default: ext_data = data_buf;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'b0;
        mem_wdata = 8'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = illegal ? RESP : XFER;
                end
            end
            XFER: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q + {30'b0, idx};
                mem_wdata = wdata_q[{idx, 3'b000} +: 8];
                if (idx == last_idx) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                // stores and rejected requests return zero data
                if (!we_q && !err_q) begin
                    rsp_rdata = ext_data;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            data_buf <= 32'b0;
            idx      <= 2'b0;
        end else if (accept) begin
            we_q     <= req_we;
            err_q    <= illegal;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            data_buf <= 32'b0;
            idx      <= 2'b0;
        end else if (state == XFER) begin
            idx <= idx + 2'd1;
            if (!we_q) begin
                data_buf[{idx, 3'b000} +: 8] <= mem_rdata;
            end
        end
    end

endmodule
